io_bus_master: RTL

//  Processor-side initiator for the single-register memory-mapped I/O port.

---
 rtl/io_bus_master.sv | 125 ++++++++++++
 1 files changed

// File: rtl/io_bus_master.sv
// Processor-side initiator for a single-register memory-mapped I/O port.
// Turns one core load/store into a one-cycle device strobe and returns data or a timeout error.
module io_bus_master #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_busy,
  output logic              cpu_resp_valid,
  output logic              cpu_err,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              io_read,
  output logic              io_write,
  output logic [DATA_W-1:0] io_wdata,
  input  logic [DATA_W-1:0] io_rdata,
  input  logic              io_ready
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic              op_q, op_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              io_read_q, io_read_d;
  logic              io_write_q, io_write_d;
  logic [DATA_W-1:0] io_wdata_q, io_wdata_d;
  logic              resp_q, resp_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      op_q       <= 1'b0;
      cnt_q      <= '0;
      io_read_q  <= 1'b0;
      io_write_q <= 1'b0;
      io_wdata_q <= '0;
      resp_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      io_read_q  <= io_read_d;
      io_write_q <= io_write_d;
      io_wdata_q <= io_wdata_d;
      resp_q     <= resp_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  // Strobes and the response pulse are computed one state early so every output leaves a flop.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    io_read_d  = 1'b0;
    io_write_d = 1'b0;
    io_wdata_d = io_wdata_q;
    resp_d     = 1'b0;
    err_d      = err_q;
    rdata_d    = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        err_d = 1'b0;
        if (cpu_req) begin
          op_d       = cpu_we;
          io_wdata_d = cpu_wdata;
          io_write_d = cpu_we;
          io_read_d  = !cpu_we;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (io_ready) begin
          if (!op_q) rdata_d = io_rdata;
          err_d   = 1'b0;
          resp_d  = 1'b1;
          state_d = S_RESP;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          resp_d  = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cpu_busy       = (state_q != S_IDLE);
  assign cpu_resp_valid = resp_q;
  assign cpu_err        = err_q;
  assign cpu_rdata      = rdata_q;
  assign io_read        = io_read_q;
  assign io_write       = io_write_q;
  assign io_wdata       = io_wdata_q;

  a_one_strobe: assert property (@(posedge clk) disable iff (!reset_n) !(io_read && io_write));
  a_resp_pulse: assert property (@(posedge clk) disable iff (!reset_n) cpu_resp_valid |=> !cpu_resp_valid);

endmodule
